// File: rtl/ex_mem_buffer.sv
// ex_mem_buffer: 2-entry EX/MEM skid FIFO with branch redirect and store lane steering.
// Define STORE_ALIGN_EN to shift sub-word store data and byte enables into their address lanes.
module ex_mem_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_branchTaken,
    input  logic [XLEN-1:0] in_branchTarget,
    input  logic [XLEN-1:0] in_storeData,
    input  logic [4:0]      in_rd,
    input  logic            in_regWrite,
    input  logic            in_memRead,
    input  logic            in_memWrite,
    input  logic [2:0]      in_funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_storeData,
    output logic [4:0]      out_rd,
    output logic            out_regWrite,
    output logic            out_memRead,
    output logic            out_memWrite,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_byteEn,
    output logic            out_misaligned,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int EW = 2 * XLEN + 11;

    logic [EW-1:0]   mem [2];
    logic [1:0]      count;
    logic            wr_ptr, rd_ptr, push, pop;
    logic [XLEN-1:0] head_store;

    assign in_ready  = count < 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign {out_result, head_store, out_rd, out_regWrite, out_memRead, out_memWrite, out_funct3} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count          <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            mem[0]         <= '0;
            mem[1]         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (flush) begin
            count          <= 2'd0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_result, in_storeData, in_rd, in_regWrite, in_memRead, in_memWrite, in_funct3};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count          <= count + {1'b0, push} - {1'b0, pop};
            redirect_valid <= push && in_branchTaken;
            if (push && in_branchTaken)
                redirect_pc <= in_branchTarget;
        end
    end

`ifdef STORE_ALIGN_EN
    logic [1:0] addr;
    logic       sub_word;
    assign addr     = out_result[1:0];
    assign sub_word = out_funct3[2:1] == 2'b00;
    assign out_byteEn = !out_memWrite         ? 4'b0000 :
                        out_funct3 == 3'b000  ? 4'b0001 << addr :
                        out_funct3 == 3'b001  ? 4'b0011 << addr : 4'b1111;
    assign out_storeData  = (out_memWrite && sub_word) ? head_store << {addr, 3'b000} : head_store;
    assign out_misaligned = out_memWrite && (out_funct3 == 3'b001 ? addr[0] :
                                             out_funct3 == 3'b010 ? |addr : 1'b0);
`else
    assign out_byteEn     = out_memWrite ? 4'b1111 : 4'b0000;
    assign out_storeData  = head_store;
    assign out_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb_ex_mem_buffer: scoreboard bench for ex_mem_buffer; expectations follow STORE_ALIGN_EN.
module tb_ex_mem_buffer;
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [3:0]  be;
        logic        mis;
        logic [4:0]  rd;
        logic        rw, mr, mw;
        logic [2:0]  f3;
    } ent_t;

    logic        clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_result = 0, in_branchTarget = 0, in_storeData = 0;
    logic        in_branchTaken = 0, in_regWrite = 0, in_memRead = 0, in_memWrite = 0;
    logic [4:0]  in_rd = 0;
    logic [2:0]  in_funct3 = 0;
    logic        in_ready, out_valid, out_regWrite, out_memRead, out_memWrite, out_misaligned, redirect_valid;
    logic [31:0] out_result, out_storeData, redirect_pc;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_byteEn;

    ent_t q[$];
    int   errors = 0, checks = 0;

    ex_mem_buffer #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_branchTaken(in_branchTaken), .in_branchTarget(in_branchTarget),
        .in_storeData(in_storeData), .in_rd(in_rd), .in_regWrite(in_regWrite),
        .in_memRead(in_memRead), .in_memWrite(in_memWrite), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_storeData(out_storeData), .out_rd(out_rd),
        .out_regWrite(out_regWrite), .out_memRead(out_memRead), .out_memWrite(out_memWrite),
        .out_funct3(out_funct3), .out_byteEn(out_byteEn), .out_misaligned(out_misaligned),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (q.size() == 0)
                chk("unexpected_output", 1, 0);
            else
                chk("scoreboard_entry",
                    {out_result, out_storeData, out_byteEn, out_misaligned, out_rd,
                     out_regWrite, out_memRead, out_memWrite, out_funct3},
                    q.pop_front());
        end
    end

    task automatic push(input logic [31:0] res, sd, tgt, input logic br, input logic [4:0] rd,
                        input logic [2:0] ctl, input logic [2:0] f3,
                        input logic [31:0] esd, input logic [3:0] ebe, input logic emis, input logic fl);
        int n = 0;
        while (!fl && !in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!fl && !in_ready)
            chk("push_in_ready_timeout", 0, 1);
        in_valid = 1; flush = fl;
        in_result = res; in_storeData = sd; in_branchTarget = tgt; in_branchTaken = br;
        in_rd = rd; {in_regWrite, in_memRead, in_memWrite} = ctl; in_funct3 = f3;
        if (!fl)
            q.push_back('{res, esd, ebe, emis, rd, ctl[2], ctl[1], ctl[0], f3});
        @(posedge clk); #1;
        in_valid = 0; flush = 0; in_branchTaken = 0;
        if (fl)
            q.delete();
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset held with a pending branch push on the input
        in_valid = 1; in_result = 32'hdead; in_branchTaken = 1; in_branchTarget = 32'h99;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_outputs", {out_result, out_storeData, out_rd, out_byteEn, out_misaligned, out_funct3}, 0);
        @(posedge clk); #1;
        in_valid = 0; in_branchTaken = 0; reset_n = 1;
        @(posedge clk); #1;

        out_ready = 0;
        push(32'h8, 0, 0, 0, 5'd1, 3'b100, 3'b000, 0, 4'b0000, 0, 0);
        push(32'h5, 0, 0, 0, 5'd2, 3'b100, 3'b000, 0, 4'b0000, 0, 0);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", out_result, 32'h8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_head_held", out_result, 32'h8);
        @(posedge clk); #1;
        drain();

        push(32'h1, 0, 32'h40, 1, 5'd0, 3'b000, 3'b000, 0, 4'b0000, 0, 0);
        @(negedge clk);
        chk("br_redirect_valid", redirect_valid, 1);
        chk("br_redirect_pc", redirect_pc, 32'h40);
        @(negedge clk);
        chk("br_redirect_pulse", redirect_valid, 0);
        chk("br_redirect_pc_hold", redirect_pc, 32'h40);
        @(posedge clk); #1;
        push(32'h2, 0, 32'h80, 1, 5'd0, 3'b000, 3'b000, 0, 4'b0000, 0, 1);
        @(negedge clk);
        chk("flush_no_redirect", redirect_valid, 0);
        chk("flush_redirect_pc", redirect_pc, 32'h40);
        @(posedge clk); #1;

        out_ready = 0;
        push(32'h11, 0, 0, 0, 5'd3, 3'b100, 3'b000, 0, 4'b0000, 0, 0);
        push(32'h22, 0, 0, 0, 5'd4, 3'b100, 3'b000, 0, 4'b0000, 0, 0);
        push(32'h33, 0, 0, 0, 5'd5, 3'b100, 3'b000, 0, 4'b0000, 0, 1);
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(negedge clk);
        chk("flush_entry_lost", out_valid, 0);
        @(posedge clk); #1;

        out_ready = 0;
`ifdef STORE_ALIGN_EN
        push(32'h2002, 32'hAB, 0, 0, 5'd0, 3'b001, 3'b000, 32'h00AB0000, 4'b0100, 0, 0);
        push(32'h2001, 32'h1234, 0, 0, 5'd0, 3'b001, 3'b001, 32'h00123400, 4'b0110, 1, 0);
`else
        push(32'h2002, 32'hAB, 0, 0, 5'd0, 3'b001, 3'b000, 32'h000000AB, 4'b1111, 0, 0);
        push(32'h2001, 32'h1234, 0, 0, 5'd0, 3'b001, 3'b001, 32'h00001234, 4'b1111, 0, 0);
`endif
        drain();
        push(32'h2004, 32'hCAFEBABE, 0, 0, 5'd0, 3'b001, 3'b010, 32'hCAFEBABE, 4'b1111, 0, 0);
        push(32'h2008, 32'h77, 0, 0, 5'd9, 3'b110, 3'b010, 32'h77, 4'b0000, 0, 0);
        drain();

        out_ready = 0;
        push(32'h100, 32'h1, 0, 0, 5'd7, 3'b100, 3'b000, 32'h1, 4'b0000, 0, 0);
        out_ready = 1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] r, s;
            r = $urandom; s = $urandom;
            push(r, s, 0, 0, 5'(i), 3'b100, 3'b000, s, 4'b0000, 0, 0);
            chk("pt_count_one", {out_valid, in_ready}, 2'b11);
        end
        drain();
        chk("scoreboard_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 SHALL have port flush  input  1  discards all buffered and incoming entries.
REQ-005 SHALL have port in_valid / in_ready  input / output  1 / 1  upstream (ALU stage) handshake.
REQ-006 SHALL have port in_result  input  XLEN  ALU result (address or writeback value).
REQ-007 SHALL have port in_branchTaken  input  1  ALU branch_taken.
REQ-008 SHALL have port in_branchTarget  input  XLEN  resolved branch/jump target.
REQ-009 SHALL have port in_storeData  input  XLEN  rs2 value for stores.
REQ-010 SHALL have port in_rd / in_regWrite / in_memRead / in_memWrite / in_funct3  input  5/1/1/1/3  control bits.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 / 1  downstream (memory stage) handshake.
REQ-012 SHALL have ports out_result, out_storeData, out_rd, out_regWrite, out_memRead, out_memWrite, out_funct3  output  widths as inputs  head-entry fields.
REQ-013 SHALL have port out_byteEn  output  4  store byte-lane mask.
REQ-014 SHALL have port out_misaligned  output  1  head store is misaligned.
REQ-015 SHALL have ports redirect_valid / redirect_pc  output  1 / XLEN  fetch redirect.

Function
REQ-016 SHALL implement a 2-entry FIFO skid buffer; occupancy count 0..2.
REQ-017 in_ready SHALL equal (count < 2), registered-state only, no combinational path from out_ready.
REQ-018 Push SHALL occur on in_valid && in_ready && !flush; pop on out_valid && out_ready.
REQ-019 out_valid SHALL equal (count != 0); outputs SHALL present the oldest entry; accepted entry visible earliest the next cycle (latency 1).
REQ-020 Simultaneous push and pop at count 1 SHALL keep count 1 and present the new entry next cycle.
REQ-021 At count 2 push SHALL be impossible; pop SHALL reduce count to 1 preserving order.
REQ-022 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-023 flush SHALL set count to 0 next cycle, dropping any same-cycle push and pop; flush has priority over all other events.
REQ-024 redirect_valid SHALL pulse high exactly one cycle, the cycle after a push whose in_branchTaken=1, with redirect_pc = that in_branchTarget; otherwise redirect_pc holds last value.
REQ-025 A push coinciding with flush SHALL NOT generate a redirect.
REQ-026 Non-store head entries SHALL drive out_byteEn = 4'b0000 and out_misaligned = 0.

Reset
REQ-027 reset_n low at a rising edge SHALL clear count to 0, redirect_valid to 0, redirect_pc and all entry fields to 0.
REQ-028 During reset in_ready SHALL be 1 (count 0) and out_valid 0; reset mid-transfer SHALL discard all entries without redirect.

Configuration
REQ-029 Macro STORE_ALIGN_EN SHALL control store lane alignment.
REQ-030 With STORE_ALIGN_EN defined, for memWrite heads: funct3 000 -> byteEn 0001<<addr[1:0], data shifted left 8*addr[1:0]; 001 -> byteEn 0011<<addr[1:0], data shifted left 8*addr[1:0], misaligned = addr[0]; 010 -> byteEn 1111, misaligned = (addr[1:0]!=0); addr = out_result.
REQ-031 Without STORE_ALIGN_EN, stores SHALL output raw storeData, byteEn 1111, misaligned 0; ports remain present.

Verification
REQ-032 Reset: hold reset_n=0 two cycles with in_valid=1 -> out_valid=0, in_ready=1, redirect_valid=0, all outputs 0.
REQ-033 Backpressure: push ADD result 0x8 then SUB result 0x5 with out_ready=0 -> count 2, in_ready=0, out_result=0x8 held; raise out_ready -> 0x8 then 0x5 in order.
REQ-034 Branch: push BEQ branchTaken=1, target 0x00000040 -> redirect_valid=1 for exactly one cycle with redirect_pc=0x40; push with flush=1 -> no redirect.
REQ-035 Flush: count 2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed entry lost.
REQ-036 Store align (macro on): SB result 0x2002, storeData 0x000000AB -> byteEn 0100, storeData 0x00AB0000; SH at 0x2001 -> misaligned=1; macro off -> byteEn 1111, data 0x000000AB.
REQ-037 Pass-through: count 1, push and pop same cycle, 20 cycles random data -> count stays 1, in-order, no loss.
